// File: rtl/event_sync_pkg.sv
// Shared definitions for the event_sync_rx receiver: edge-mode encodings,
// arbiter state enumeration and a constant-foldable clog2 helper.
package event_sync_pkg;

    // Per-channel edge qualification modes (2 bits per channel in EDGE_MODE).
    localparam logic [1:0] MODE_BOTH = 2'b00;
    localparam logic [1:0] MODE_RISE = 2'b01;
    localparam logic [1:0] MODE_FALL = 2'b10;
    localparam logic [1:0] MODE_OFF  = 2'b11;

    // Output arbiter states.
    typedef enum logic {
        ARB_IDLE    = 1'b0,
        ARB_PRESENT = 1'b1
    } arb_state_t;

    // Ceiling log2; clog2(1) = 0, clog2(4) = 2, clog2(5) = 3.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/event_sync_rx_sync_chain.sv
// One channel of the receiver front end: a SYNC_SIZE-flop synchroniser
// followed by a history flop, so the parent can compare the current synced
// level with the level one cycle earlier.
module sync_chain #(
    parameter int SYNC_SIZE = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic sync,
    output logic hist
);

    logic [SYNC_SIZE-1:0] stages;

    // Shift the asynchronous input through the synchroniser and keep one
    // cycle of history of the synchronised level.
    // NOTE: non-blocking assignments let every stage sample its predecessor's
    // old value, which is what makes this a shift register rather than a wire.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stages <= '0;
            hist   <= 1'b0;
        end else begin
            stages <= {stages[SYNC_SIZE-2:0], d};
            hist   <= stages[SYNC_SIZE-1];
        end
    end

    assign sync = stages[SYNC_SIZE-1];

endmodule

// File: rtl/event_sync_rx.sv
// Multi-channel event receiver: synchronises CHANNELS asynchronous toggle or
// level inputs, qualifies edges per channel, queues events in saturating
// counters and presents them one at a time through a round-robin
// valid/ready port.
module event_sync_rx
    import event_sync_pkg::*;
#(
    parameter int                    CHANNELS  = 4,
    parameter int                    SYNC_SIZE = 3,
    parameter int                    CNT_W     = 4,
    parameter logic [2*CHANNELS-1:0] EDGE_MODE = '0,
    localparam int                   CH_W      = (CHANNELS > 1) ? clog2(CHANNELS) : 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [CHANNELS-1:0] async_in,
    output logic [CHANNELS-1:0] evt_pulse,
    output logic                evt_valid,
    output logic [CH_W-1:0]     evt_chan,
    input  logic                evt_ready,
    output logic [CHANNELS-1:0] ovf,
    input  logic [CHANNELS-1:0] ovf_clr
);

    localparam int               PRIME_CYCLES = SYNC_SIZE + 1;
    localparam int               PRIME_W      = clog2(PRIME_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX      = '1;

    logic [CHANNELS-1:0] sync_lvl;
    logic [CHANNELS-1:0] hist;
    logic [CHANNELS-1:0] qual;
    logic [CHANNELS-1:0] dec;
    logic [CHANNELS-1:0] busy;
    logic [CNT_W-1:0]    cnt [CHANNELS];
    logic [PRIME_W-1:0]  prime_cnt;
    logic                primed;
    arb_state_t          state;
    logic [CH_W-1:0]     rr;
    logic [CH_W-1:0]     pick_chan;
    logic                pick_found;

    for (genvar g = 0; g < CHANNELS; g++) begin : g_sync
        sync_chain #(
            .SYNC_SIZE (SYNC_SIZE)
        ) u_sync (
            .clk  (clk),
            .rst  (rst),
            .d    (async_in[g]),
            .sync (sync_lvl[g]),
            .hist (hist[g])
        );
    end

    // Count the cycles after reset release during which the history flops
    // are still adopting the input level; edges are ignored until it tops out.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prime_cnt <= '0;
        end else if (!primed) begin
            prime_cnt <= prime_cnt + 1'b1;
        end
    end

    assign primed = (prime_cnt == PRIME_W'(PRIME_CYCLES));

    // Qualify the raw edge of each channel against its edge mode.
    // NOTE: every variable driven here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        qual = '0;
        for (int n = 0; n < CHANNELS; n++) begin
            case (EDGE_MODE[2*n +: 2])
                MODE_BOTH: qual[n] = sync_lvl[n] ^ hist[n];
                MODE_RISE: qual[n] = sync_lvl[n] & ~hist[n];
                MODE_FALL: qual[n] = ~sync_lvl[n] & hist[n];
                default:   qual[n] = 1'b0;
            endcase
        end
        if (!primed) begin
            qual = '0;
        end
    end

    // Decode the accepted handshake into a per-channel decrement and flag
    // channels with queued events.
    always_comb begin
        dec  = '0;
        busy = '0;
        for (int n = 0; n < CHANNELS; n++) begin
            dec[n]  = evt_valid && evt_ready && (evt_chan == CH_W'(n));
            busy[n] = (cnt[n] != '0);
        end
    end

    // Register the event strobes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            evt_pulse <= '0;
        end else begin
            evt_pulse <= qual;
        end
    end

    // Saturating pending-event counters and sticky overflow flags; a new
    // event beats a simultaneous clear so no overflow is ever lost.
    // NOTE: the counters are individual flops, not a RAM, so they are reset
    // like any other state to guarantee no phantom events after reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int n = 0; n < CHANNELS; n++) begin
                cnt[n] <= '0;
            end
            ovf <= '0;
        end else begin
            for (int n = 0; n < CHANNELS; n++) begin
                if (qual[n] && !dec[n]) begin
                    if (cnt[n] != CNT_MAX) begin
                        cnt[n] <= cnt[n] + 1'b1;
                    end
                end else if (!qual[n] && dec[n]) begin
                    cnt[n] <= cnt[n] - 1'b1;
                end

                if (qual[n] && !dec[n] && (cnt[n] == CNT_MAX)) begin
                    ovf[n] <= 1'b1;
                end else if (ovf_clr[n]) begin
                    ovf[n] <= 1'b0;
                end
            end
        end
    end

    // Round-robin pick: the busy channel with the smallest forward distance
    // from the pointer rr.
    always_comb begin
        int best_d;
        int d;
        best_d     = CHANNELS;
        d          = 0;
        pick_found = 1'b0;
        pick_chan  = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            d = (c + CHANNELS - int'(rr)) % CHANNELS;
            if (busy[c] && (d < best_d)) begin
                best_d     = d;
                pick_chan  = CH_W'(c);
                pick_found = 1'b1;
            end
        end
    end

    // Output arbiter. After a handshake the block drops to IDLE for one
    // cycle; that bubble is where re-arbitration happens against the
    // already-decremented counters and the advanced pointer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ARB_IDLE;
            evt_valid <= 1'b0;
            evt_chan  <= '0;
            rr        <= '0;
        end else begin
            case (state)
                ARB_IDLE: begin
                    if (pick_found) begin
                        evt_chan  <= pick_chan;
                        evt_valid <= 1'b1;
                        state     <= ARB_PRESENT;
                    end
                end
                ARB_PRESENT: begin
                    if (evt_ready) begin
                        evt_valid <= 1'b0;
                        state     <= ARB_IDLE;
                        rr        <= (evt_chan == CH_W'(CHANNELS - 1)) ? '0 : evt_chan + 1'b1;
                    end
                end
                default: begin
                    state     <= ARB_IDLE;
                    evt_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_event_sync_rx.sv
// Self-checking bench for event_sync_rx. Instance a uses all-toggle edge
// modes with 2-bit counters (priming, latency, round-robin, saturation,
// simultaneous inc/dec, reset mid-operation); instance b uses mixed edge
// modes and is driven from a table of toggle vectors.
module tb_event_sync_rx;

    logic       clk = 1'b0;
    logic       rst;

    logic [3:0] in_a, pulse_a, ovf_a, clr_a;
    logic       valid_a, ready_a;
    logic [1:0] chan_a;

    logic [3:0] in_b, pulse_b, ovf_b, clr_b;
    logic       valid_b, ready_b;
    logic [1:0] chan_b;

    int tests  = 0;
    int failed = 0;
    int pc [4];

    typedef struct {
        int chan;
        int n_toggles;
        int exp_events;
    } edge_vec_t;

    edge_vec_t vecs [9];

    always #5 clk = ~clk;

    event_sync_rx #(
        .CHANNELS  (4),
        .SYNC_SIZE (3),
        .CNT_W     (2),
        .EDGE_MODE (8'b00_00_00_00)
    ) dut_a (
        .clk       (clk),
        .rst       (rst),
        .async_in  (in_a),
        .evt_pulse (pulse_a),
        .evt_valid (valid_a),
        .evt_chan  (chan_a),
        .evt_ready (ready_a),
        .ovf       (ovf_a),
        .ovf_clr   (clr_a)
    );

    event_sync_rx #(
        .CHANNELS  (4),
        .SYNC_SIZE (3),
        .CNT_W     (4),
        .EDGE_MODE (8'b11_10_01_00)
    ) dut_b (
        .clk       (clk),
        .rst       (rst),
        .async_in  (in_b),
        .evt_pulse (pulse_b),
        .evt_valid (valid_b),
        .evt_chan  (chan_b),
        .evt_ready (ready_b),
        .ovf       (ovf_b),
        .ovf_clr   (clr_b)
    );

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        tests++;
        if (actual !== expected) begin
            failed++;
            $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Pulse reset for two cycles, then let both instances finish priming.
    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (8) @(negedge clk);
    endtask

    // Bounded wait for instance a to present an event.
    task automatic wait_valid_a(input string name);
        int k;
        k = 0;
        while (!valid_a && k < 20) begin
            @(negedge clk);
            k++;
        end
        check(name, valid_a, 1);
    endtask

    // Count accepted handshakes on instance a over a window (ready held high).
    task automatic count_accepts(input int cycles, output int n);
        n = 0;
        for (int k = 0; k < cycles; k++) begin
            if (valid_a && ready_a) n++;
            @(negedge clk);
        end
    endtask

    // Advance instance b one cycle, accumulating its event strobes.
    task automatic tick_b();
        @(negedge clk);
        for (int n = 0; n < 4; n++) begin
            pc[n] += int'(pulse_b[n]);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int first_k, npulse, n_acc;
        logic v5, v6, later_valid, pulse_seen, valid_seen, stable;
        logic [1:0] c5;
        int order [3];
        int n_order;

        vecs[0] = '{0, 2, 2};  // both edges: 0->1->0
        vecs[1] = '{1, 2, 1};  // rise only
        vecs[2] = '{2, 2, 1};  // fall only
        vecs[3] = '{3, 2, 0};  // disabled
        vecs[4] = '{1, 1, 1};  // ch1 0->1: rise
        vecs[5] = '{1, 1, 0};  // ch1 1->0: not a rise
        vecs[6] = '{2, 1, 0};  // ch2 0->1: not a fall
        vecs[7] = '{2, 3, 2};  // ch2 1->0->1->0: two falls
        vecs[8] = '{0, 3, 3};  // ch0 three toggles

        rst     = 1'b1;
        in_a    = 4'b1111;
        ready_a = 1'b0;
        clr_a   = '0;
        in_b    = '0;
        ready_b = 1'b1;
        clr_b   = '0;

        // Reset state with a static high input.
        repeat (2) @(negedge clk);
        check("reset_valid", valid_a, 0);
        check("reset_chan", chan_a, 0);
        check("reset_ovf", ovf_a, 0);
        check("reset_pulse", pulse_a, 0);

        // Priming: static high input held through release gives no events.
        rst = 1'b0;
        pulse_seen = 1'b0;
        valid_seen = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            pulse_seen |= |pulse_a;
            valid_seen |= valid_a;
        end
        check("prime_no_pulse", pulse_seen, 0);
        check("prime_no_valid", valid_seen, 0);

        // Latency on channel 2, accepted immediately.
        @(negedge clk);
        rst  = 1'b1;
        in_a = 4'b0000;
        do_reset();
        ready_a = 1'b1;
        in_a[2] = 1'b1;
        first_k = -1;
        npulse = 0;
        later_valid = 1'b0;
        v5 = 1'b0;
        v6 = 1'b1;
        c5 = 2'd0;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (pulse_a[2] && first_k < 0) first_k = k;
            npulse += int'(pulse_a[2]);
            if (k == 5) begin
                v5 = valid_a;
                c5 = chan_a;
            end
            if (k == 6) v6 = valid_a;
            if (k >= 6) later_valid |= valid_a;
        end
        check("lat_pulse_cycle", first_k, 4);
        check("lat_pulse_count", npulse, 1);
        check("lat_valid", v5, 1);
        check("lat_chan", c5, 2);
        check("lat_bubble", v6, 0);
        check("lat_drained", later_valid, 0);

        // Round-robin with backpressure: ch0, ch1, ch3 one event each.
        ready_a = 1'b0;
        do_reset();
        in_a = in_a ^ 4'b1011;
        wait_valid_a("rr_wait_valid");
        check("rr_first_chan", chan_a, 0);
        stable = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            stable &= valid_a && (chan_a == 2'd0);
        end
        check("rr_hold_stable", stable, 1);
        ready_a = 1'b1;
        order = '{-1, -1, -1};
        n_order = 0;
        for (int k = 0; k < 20 && n_order < 3; k++) begin
            if (valid_a) begin
                order[n_order] = int'(chan_a);
                n_order++;
            end
            @(negedge clk);
        end
        check("rr_accept_count", n_order, 3);
        check("rr_order0", order[0], 0);
        check("rr_order1", order[1], 1);
        check("rr_order2", order[2], 3);
        count_accepts(6, n_acc);
        check("rr_drained", n_acc, 0);

        // Reset mid-operation discards a pending event.
        ready_a = 1'b0;
        in_a[0] = ~in_a[0];
        wait_valid_a("midrst_wait_valid");
        rst = 1'b1;
        #1;
        check("midrst_valid_low", valid_a, 0);
        @(negedge clk);
        rst = 1'b0;
        pulse_seen = 1'b0;
        valid_seen = 1'b0;
        for (int k = 0; k < 15; k++) begin
            @(negedge clk);
            pulse_seen |= |pulse_a;
            valid_seen |= valid_a;
        end
        check("midrst_no_pulse", pulse_seen, 0);
        check("midrst_no_valid", valid_seen, 0);

        // Saturation of a 2-bit counter and sticky overflow.
        for (int t = 0; t < 5; t++) begin
            in_a[1] = ~in_a[1];
            repeat (4) @(negedge clk);
        end
        repeat (4) @(negedge clk);
        check("sat_ovf_set", ovf_a, 4'b0010);
        in_a[1] = ~in_a[1];
        repeat (3) @(negedge clk);
        clr_a[1] = 1'b1;
        @(negedge clk);
        clr_a[1] = 1'b0;
        check("sat_set_beats_clr", ovf_a[1], 1);
        clr_a[1] = 1'b1;
        @(negedge clk);
        clr_a[1] = 1'b0;
        check("sat_clr_alone", ovf_a[1], 0);
        ready_a = 1'b1;
        count_accepts(20, n_acc);
        check("sat_drain_count", n_acc, 3);

        // Simultaneous increment and decrement on channel 0.
        ready_a = 1'b0;
        do_reset();
        in_a[0] = ~in_a[0];
        wait_valid_a("simul_wait_valid");
        check("simul_chan", chan_a, 0);
        in_a[0] = ~in_a[0];
        repeat (3) @(negedge clk);
        ready_a = 1'b1;
        @(negedge clk);
        ready_a = 1'b0;
        check("simul_bubble", valid_a, 0);
        @(negedge clk);
        check("simul_represent", valid_a, 1);
        check("simul_rechan", chan_a, 0);
        ready_a = 1'b1;
        count_accepts(10, n_acc);
        check("simul_remaining", n_acc, 1);

        // Edge-mode table on instance b.
        do_reset();
        for (int e = 0; e < 9; e++) begin
            int total;
            for (int n = 0; n < 4; n++) pc[n] = 0;
            for (int t = 0; t < vecs[e].n_toggles; t++) begin
                tick_b();
                in_b[vecs[e].chan] = ~in_b[vecs[e].chan];
                repeat (4) tick_b();
            end
            repeat (8) tick_b();
            total = pc[0] + pc[1] + pc[2] + pc[3];
            check($sformatf("edge_vec%0d_chan", e), pc[vecs[e].chan], vecs[e].exp_events);
            check($sformatf("edge_vec%0d_total", e), total, vecs[e].exp_events);
        end
        check("edge_no_backlog", valid_b, 0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
